// File: rtl/rc4_prga_decrypt_pkg.sv
// Shared types and constants for the RC4 PRGA / decrypt stage.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_I,
    LATCH_I,
    ADDR_J,
    LATCH_J,
    WR_I,
    WR_J,
    ADDR_F,
    LATCH_F,
    WR_PT,
    DONE
  } prga_state_t;

  localparam int unsigned PRGA_CYCLES_PER_BYTE = 9;

  localparam logic [7:0] PT_CHAR_LO    = 8'h61;
  localparam logic [7:0] PT_CHAR_HI    = 8'h7A;
  localparam logic [7:0] PT_CHAR_SPACE = 8'h20;

endpackage

// File: rtl/rc4_prga_decrypt_char_check.sv
// Plaintext byte classifier: valid when the byte is a space or a lowercase letter.
module prga_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       valid
);

  // Pure combinational range test against the accepted character set.
  always_comb begin
    valid = (data == PT_CHAR_SPACE) || ((data >= PT_CHAR_LO) && (data <= PT_CHAR_HI));
  end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA keystream generation and ciphertext decryption over a shared S-memory port.
// Optional plaintext check enabled by defining PRGA_ASCII_CHECK_EN.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned K_W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_sig,
  output logic           prga_finished,
  output logic           key_invalid,
  output logic [7:0]     s_address,
  output logic [7:0]     s_wdata,
  output logic           s_wren,
  input  logic [7:0]     s_rdata,
  output logic [K_W-1:0] ct_address,
  input  logic [7:0]     ct_rdata,
  output logic [K_W-1:0] pt_address,
  output logic [7:0]     pt_wdata,
  output logic           pt_wren
);

  prga_state_t state, state_next;

  logic [K_W-1:0] k;
  logic [7:0]     j, si, sj, f, ct;
  logic [7:0]     i_idx, pt_byte;
  logic           last_byte, stop;

  // i is never stored; it always follows the message index.
  assign i_idx     = 8'(k) + 8'd1;
  assign pt_byte   = f ^ ct;
  assign last_byte = (k == K_W'(MSG_LEN - 1));

`ifdef PRGA_ASCII_CHECK_EN
  logic char_ok, key_inv_q;

  prga_char_check u_char_check (
    .data  (pt_byte),
    .valid (char_ok)
  );

  assign stop        = last_byte || !char_ok;
  assign key_invalid = key_inv_q & ~reset;

  // Invalid-key flag: raised on a rejected byte, cleared when a new run starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_inv_q <= 1'b0;
    end else if (state == IDLE && start_sig) begin
      key_inv_q <= 1'b0;
    end else if (state == WR_PT && !char_ok) begin
      key_inv_q <= 1'b1;
    end
  end
`else
  assign stop        = last_byte;
  assign key_invalid = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: message index, j and the bytes latched from memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      k  <= '0;
      j  <= '0;
      si <= '0;
      sj <= '0;
      f  <= '0;
      ct <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_sig) begin
            k <= '0;
            j <= '0;
          end
        end
        LATCH_I: begin
          si <= s_rdata;
          j  <= j + s_rdata;
        end
        LATCH_J: sj <= s_rdata;
        LATCH_F: begin
          f  <= s_rdata;
          ct <= ct_rdata;
        end
        WR_PT: begin
          if (!stop) k <= k + K_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state and memory-port outputs; outputs are forced low while reset is
  // high so that no write lands on the reset edge.
  always_comb begin
    state_next    = state;
    prga_finished = 1'b0;
    s_address     = '0;
    s_wdata       = '0;
    s_wren        = 1'b0;
    ct_address    = '0;
    pt_address    = '0;
    pt_wdata      = '0;
    pt_wren       = 1'b0;
    case (state)
      IDLE:    if (start_sig) state_next = ADDR_I;
      ADDR_I: begin
        s_address  = i_idx;
        state_next = LATCH_I;
      end
      LATCH_I: state_next = ADDR_J;
      ADDR_J: begin
        s_address  = j;
        state_next = LATCH_J;
      end
      LATCH_J: state_next = WR_I;
      WR_I: begin
        s_address  = i_idx;
        s_wdata    = sj;
        s_wren     = 1'b1;
        state_next = WR_J;
      end
      WR_J: begin
        s_address  = j;
        s_wdata    = si;
        s_wren     = 1'b1;
        state_next = ADDR_F;
      end
      ADDR_F: begin
        s_address  = si + sj;
        ct_address = k;
        state_next = LATCH_F;
      end
      LATCH_F: state_next = WR_PT;
      WR_PT: begin
        pt_address = k;
        pt_wdata   = pt_byte;
        pt_wren    = 1'b1;
        state_next = stop ? DONE : ADDR_I;
      end
      DONE: begin
        prga_finished = 1'b1;
        if (!start_sig) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      prga_finished = 1'b0;
      s_address     = '0;
      s_wdata       = '0;
      s_wren        = 1'b0;
      ct_address    = '0;
      pt_address    = '0;
      pt_wdata      = '0;
      pt_wren       = 1'b0;
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt; honours PRGA_ASCII_CHECK_EN when defined.
module tb_rc4_prga_decrypt;
  import rc4_pkg::*;

  localparam int unsigned MSG_LEN = 32;
  localparam int unsigned K_W     = 8;
`ifdef PRGA_ASCII_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] arr_t [256];

  logic           clk = 1'b0;
  logic           reset, start_sig;
  logic           prga_finished, key_invalid;
  logic [7:0]     s_address, s_wdata, s_rdata;
  logic           s_wren;
  logic [K_W-1:0] ct_address, pt_address;
  logic [7:0]     ct_rdata, pt_wdata;
  logic           pt_wren;

  always #5 clk = ~clk;

  rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .K_W(K_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_sig     (start_sig),
    .prga_finished (prga_finished),
    .key_invalid   (key_invalid),
    .s_address     (s_address),
    .s_wdata       (s_wdata),
    .s_wren        (s_wren),
    .s_rdata       (s_rdata),
    .ct_address    (ct_address),
    .ct_rdata      (ct_rdata),
    .pt_address    (pt_address),
    .pt_wdata      (pt_wdata),
    .pt_wren       (pt_wren)
  );

  arr_t smem, ctmem, ptmem, s_init, ct_init;
  logic load = 1'b0;

  // Memory models: registered address, one-cycle read latency.
  always @(posedge clk) begin
    if (load) begin
      smem  <= s_init;
      ctmem <= ct_init;
      ptmem <= '{default: 8'h00};
    end else begin
      if (s_wren)  smem[s_address]  <= s_wdata;
      if (pt_wren) ptmem[pt_address] <= pt_wdata;
    end
    s_rdata  <= smem[s_address];
    ct_rdata <= ctmem[ct_address];
  end

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned sw_cnt, pw_cnt;
  logic [15:0] exp_sw[$], exp_pw[$], all_sw[$];
  logic [15:0] first_sw [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Plain RC4 PRGA over an array, producing the expected write streams.
  task automatic build_model(input arr_t s_in, input arr_t ct_in, input bit check,
                             input int unsigned max_bytes, output arr_t s_out,
                             output arr_t ks, output int unsigned nb, output logic inval);
    logic [7:0] ii, jj, t, p, fi;
    s_out = s_in;
    ks    = '{default: 8'h00};
    nb    = 0;
    inval = 1'b0;
    jj    = 8'h00;
    exp_sw.delete();
    exp_pw.delete();
    for (int unsigned n = 0; n < max_bytes; n++) begin
      ii = 8'(n + 1);
      jj = jj + s_out[ii];
      exp_sw.push_back({ii, s_out[jj]});
      exp_sw.push_back({jj, s_out[ii]});
      t = s_out[ii]; s_out[ii] = s_out[jj]; s_out[jj] = t;
      fi = s_out[ii] + s_out[jj];
      ks[n] = s_out[fi];
      p = ks[n] ^ ct_in[n];
      exp_pw.push_back({8'(n), p});
      nb++;
      if (check && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7a))) begin
        inval = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_mem(input arr_t s_in, input arr_t ct_in);
    s_init  = s_in;
    ct_init = ct_in;
    load    = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    sw_cnt = 0;
    pw_cnt = 0;
  endtask

  // Raise start (called just after a rising edge with the DUT idle) and count
  // cycles after the acceptance edge until prga_finished, with a bound.
  task automatic do_run(input bit pulse, output int unsigned cyc);
    start_sig = 1'b1;
    @(posedge clk);
    if (pulse) #1 start_sig = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!prga_finished && cyc < 9 * MSG_LEN + 20);
  endtask

  task automatic finish_checks(input string nm, input arr_t s_exp, input arr_t ks,
                               input arr_t ct, input int unsigned nb, input logic inv,
                               input int unsigned cyc);
    int unsigned bad_s, bad_p;
    chk({nm, "_done_cycle"}, cyc, PRGA_CYCLES_PER_BYTE * nb + 1);
    chk({nm, "_key_invalid"}, 32'(key_invalid), 32'(inv));
    chk({nm, "_pending_writes"}, 32'(exp_sw.size() + exp_pw.size()), 0);
    chk({nm, "_s_wren_count"}, sw_cnt, 2 * nb);
    chk({nm, "_pt_wren_count"}, pw_cnt, nb);
    bad_s = 0;
    for (int n = 0; n < 256; n++) if (smem[n] !== s_exp[n]) bad_s++;
    chk({nm, "_s_memory"}, bad_s, 0);
    bad_p = 0;
    for (int unsigned n = 0; n < nb; n++) if (ptmem[n] !== (ks[n] ^ ct[n])) bad_p++;
    chk({nm, "_pt_memory"}, bad_p, 0);
  endtask

  initial begin
    arr_t ident, zero, ct_txt, s_exp, ks, s_part;
    int unsigned nb, cyc, bad;
    logic inv;
    logic [255:0] txt;

    reset = 1'b1;
    start_sig = 1'b0;
    sw_cnt = 0;
    pw_cnt = 0;
    txt = "attack at dawn attack at dusk ok";
    for (int n = 0; n < 256; n++) begin
      ident[n] = 8'(n);
      zero[n]  = 8'h00;
    end

    // Compare process: every write strobe is checked against the model streams.
    fork
      forever begin
        @(negedge clk);
        if (s_wren) begin
          if (sw_cnt < 2) first_sw[sw_cnt] = {s_address, s_wdata};
          sw_cnt++;
          if (exp_sw.size() == 0) begin
            vectors++; errors++;
            $display("FAIL s_wr_extra: got write 0x%0h, expected none", {s_address, s_wdata});
          end else chk("s_wr", 32'({s_address, s_wdata}), 32'(exp_sw.pop_front()));
        end
        if (pt_wren) begin
          pw_cnt++;
          if (exp_pw.size() == 0) begin
            vectors++; errors++;
            $display("FAIL pt_wr_extra: got write 0x%0h, expected none", {8'(pt_address), pt_wdata});
          end else chk("pt_wr", 32'({8'(pt_address), pt_wdata}), 32'(exp_pw.pop_front()));
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_s_port", 32'({s_address, s_wdata, s_wren}), 0);
    chk("reset_other_outputs",
        32'({prga_finished, key_invalid, ct_address, pt_address, pt_wdata, pt_wren}), 0);

    // Model pins against hand-computed RC4 on the identity permutation.
    build_model(ident, zero, 1'b0, 2, s_exp, ks, nb, inv);
    chk("model_ks0", 32'(ks[0]), 32'h02);
    chk("model_ks1", 32'(ks[1]), 32'h05);
    chk("model_s2", 32'(s_exp[2]), 32'h03);
    chk("model_s3", 32'(s_exp[3]), 32'h02);

    // Test A: identity S, zero ciphertext (also the i==j case on byte 0).
    @(posedge clk); #1;
    load_mem(ident, zero);
    build_model(ident, zero, CHK, MSG_LEN, s_exp, ks, nb, inv);
    do_run(1'b0, cyc);
    start_sig = 1'b0;
    finish_checks("tA", s_exp, ks, zero, nb, inv, cyc);
    chk("tA_pt0_literal", 32'(ptmem[0]), 32'h02);
    chk("tA_ieqj_wr_i", 32'(first_sw[0]), 32'h0101);
    chk("tA_ieqj_wr_j", 32'(first_sw[1]), 32'h0101);
`ifdef PRGA_ASCII_CHECK_EN
    chk("tA_done_literal", cyc, 10);
    chk("tA_pt1_literal", 32'(ptmem[1]), 32'h00);
    chk("tA_key_invalid_literal", 32'(key_invalid), 1);
`else
    chk("tA_done_literal", cyc, 289);
    chk("tA_pt1_literal", 32'(ptmem[1]), 32'h05);
`endif

    // Ciphertext that decrypts to a lowercase text under the identity S.
    build_model(ident, zero, 1'b0, MSG_LEN, s_exp, ks, nb, inv);
    for (int n = 0; n < 256; n++) ct_txt[n] = 8'h00;
    for (int n = 0; n < 32; n++) ct_txt[n] = ks[n] ^ txt[255 - 8 * n -: 8];

    // Test B: full message recovered as ASCII text.
    @(posedge clk); #1;
    load_mem(ident, ct_txt);
    build_model(ident, ct_txt, CHK, MSG_LEN, s_exp, ks, nb, inv);
    do_run(1'b1, cyc);
    finish_checks("tB", s_exp, ks, ct_txt, nb, inv, cyc);
    bad = 0;
    for (int n = 0; n < 32; n++) if (ptmem[n] !== txt[255 - 8 * n -: 8]) bad++;
    chk("tB_ascii_text", bad, 0);
    chk("tB_pt_wren_literal", pw_cnt, 32);
    chk("tB_s_wren_literal", sw_cnt, 64);

    // Test C: reset during WR_J of byte 5, then restart on the modified S.
    @(posedge clk); #1;
    load_mem(ident, ct_txt);
    build_model(ident, ct_txt, CHK, MSG_LEN, s_exp, ks, nb, inv);
    all_sw = exp_sw;
    start_sig = 1'b1;
    @(posedge clk);
    #1 start_sig = 1'b0;
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("tC_swren_in_reset", 32'(s_wren), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("tC_idle_s_port", 32'({s_address, s_wdata, s_wren}), 0);
    chk("tC_idle_other",
        32'({prga_finished, key_invalid, ct_address, pt_address, pt_wdata, pt_wren}), 0);
    chk("tC_s_writes_before_reset", sw_cnt, 11);
    chk("tC_pt_writes_before_reset", pw_cnt, 5);
    s_part = ident;
    for (int n = 0; n < 11; n++) s_part[all_sw[n][15:8]] = all_sw[n][7:0];
    bad = 0;
    for (int n = 0; n < 256; n++) if (smem[n] !== s_part[n]) bad++;
    chk("tC_s_memory_after_reset", bad, 0);
    exp_sw.delete();
    exp_pw.delete();
    @(posedge clk); #1;
    sw_cnt = 0;
    pw_cnt = 0;
    build_model(s_part, ct_txt, CHK, MSG_LEN, s_exp, ks, nb, inv);
    do_run(1'b1, cyc);
    finish_checks("tC_restart", s_exp, ks, ct_txt, nb, inv, cyc);

    // Test D: start held high long after completion, then a second pulsed run.
    @(posedge clk); #1;
    load_mem(ident, ct_txt);
    build_model(ident, ct_txt, CHK, MSG_LEN, s_exp, ks, nb, inv);
    do_run(1'b0, cyc);
    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (prga_finished !== 1'b1) bad++;
    end
    chk("tD_done_held", bad, 0);
    start_sig = 1'b0;
    @(negedge clk);
    chk("tD_done_drops", 32'(prga_finished), 0);
    finish_checks("tD_first", s_exp, ks, ct_txt, nb, inv, cyc);
    @(posedge clk); #1;
    load_mem(ident, ct_txt);
    build_model(ident, ct_txt, CHK, MSG_LEN, s_exp, ks, nb, inv);
    do_run(1'b1, cyc);
    finish_checks("tD_second", s_exp, ks, ct_txt, nb, inv, cyc);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
